// File: rtl/exc_pkg.sv
// Shared encodings for the exception/interrupt control stage feeding CP0:
// exception codes, CP0 register numbers, mux selects and FSM states.
package exc_pkg;

  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;
  localparam logic [4:0] EXC_UNIMPL = 5'd10;
  localparam logic [4:0] EXC_OVR    = 5'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  typedef enum logic [1:0] {
    SELPC_SEQ = 2'd0,
    SELPC_EPC = 2'd1,
    SELPC_VEC = 2'd2
  } selpc_e;

  typedef enum logic [1:0] {
    MFC0_ALU    = 2'd0,
    MFC0_STATUS = 2'd1,
    MFC0_CAUSE  = 2'd2,
    MFC0_EPC    = 2'd3
  } mfc0_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // ExcCode lives in cause[6:2]; every other cause bit reads as zero.
  function automatic logic [31:0] cause_word(input logic [4:0] code);
    return {25'd0, code, 2'b00};
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline-side bundle of the exception controller: decode events in,
// CP0 strobes, cause word and cancel strobes out.
interface exc_ctrl_if;

  logic        intr;
  logic        intr_ack;
  logic        syscall_id;
  logic        unimpl_id;
  logic        eret_id;
  logic        mfc0_id;
  logic        mtc0_id;
  logic [4:0]  rd_id;
  logic        ovr_exe;
  logic        in_slot_id;
  logic        stall_id;
  logic [31:0] sta;
  logic        exc;
  logic        inta;
  logic        mtc0;
  logic        wsta;
  logic        wcau;
  logic        wepc;
  logic [1:0]  mfc0;
  logic [1:0]  selpc;
  logic [31:0] cause;
  logic        cancel_id;
  logic        cancel_if;

  modport slave (
    input  intr, syscall_id, unimpl_id, eret_id, mfc0_id, mtc0_id, rd_id,
           ovr_exe, in_slot_id, stall_id, sta,
    output intr_ack, exc, inta, mtc0, wsta, wcau, wepc, mfc0, selpc, cause,
           cancel_id, cancel_if
  );

  modport master (
    output intr, syscall_id, unimpl_id, eret_id, mfc0_id, mtc0_id, rd_id,
           ovr_exe, in_slot_id, stall_id, sta,
    input  intr_ack, exc, inta, mtc0, wsta, wcau, wepc, mfc0, selpc, cause,
           cancel_id, cancel_if
  );

endinterface

// File: rtl/exc_ctrl_intr_sync.sv
// Brings the asynchronous interrupt line into the clock domain and flags
// each rising edge of the synchronised level for one cycle.
module intr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic intr,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], intr};
    last_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt control ahead of CP0: prioritises events, drives CP0
// strobes and the cause word, and flushes the front end after a redirect.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  exc_ctrl_if.slave   bus
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       int_pend_q, int_pend_d;
  logic       intr_rise;

  logic idle, id_ok;
  logic ovr_ev, unimpl_ev, sys_ev, int_ev, take, int_taken;
  logic eret_ev, mtc0_ev, mfc0_ev;
  logic unused_sta_hi;

  assign unused_sta_hi = ^bus.sta[31:4];

  intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
    .clk  (clk),
    .rst  (rst),
    .intr (bus.intr),
    .rise (intr_rise)
  );

  // Overflow comes from EX and ignores the ID stall; everything else needs a live ID slot.
  always_comb begin
    idle      = (state_q == IDLE) & ~rst;
    id_ok     = idle & ~bus.stall_id;
    ovr_ev    = idle & bus.ovr_exe & bus.sta[3];
    unimpl_ev = id_ok & bus.unimpl_id & bus.sta[2];
    sys_ev    = id_ok & bus.syscall_id & bus.sta[1];
    int_ev    = id_ok & int_pend_q & bus.sta[0] & ~bus.in_slot_id;
    take      = ovr_ev | unimpl_ev | sys_ev | int_ev;
    int_taken = int_ev & ~ovr_ev & ~unimpl_ev & ~sys_ev;
    eret_ev   = id_ok & bus.eret_id & ~take;
    mtc0_ev   = id_ok & bus.mtc0_id & ~take & ~bus.eret_id;
    mfc0_ev   = id_ok & bus.mfc0_id & ~take & ~bus.eret_id;
  end

  always_comb begin
    bus.exc       = 1'b0;
    bus.inta      = 1'b0;
    bus.intr_ack  = 1'b0;
    bus.mtc0      = 1'b0;
    bus.wsta      = 1'b0;
    bus.wcau      = 1'b0;
    bus.wepc      = 1'b0;
    bus.mfc0      = MFC0_ALU;
    bus.selpc     = SELPC_SEQ;
    bus.cause     = '0;
    bus.cancel_id = 1'b0;
    bus.cancel_if = (state_q == FLUSH) & ~rst;
    if (take) begin
      bus.exc   = 1'b1;
      bus.wsta  = 1'b1;
      bus.wcau  = 1'b1;
      bus.wepc  = 1'b1;
      bus.selpc = SELPC_VEC;
      if (ovr_ev) begin
        bus.cause     = cause_word(EXC_OVR);
        bus.cancel_id = 1'b1;
      end else if (unimpl_ev) begin
        bus.cause = cause_word(EXC_UNIMPL);
      end else if (sys_ev) begin
        bus.cause = cause_word(EXC_SYS);
      end else begin
        bus.cause    = cause_word(EXC_INT);
        bus.inta     = 1'b1;
        bus.intr_ack = 1'b1;
      end
    end else if (eret_ev) begin
      bus.wsta  = 1'b1;
      bus.selpc = SELPC_EPC;
    end else begin
      if (mtc0_ev) begin
        bus.mtc0 = 1'b1;
        case (bus.rd_id)
          CP0_STATUS: bus.wsta = 1'b1;
          CP0_CAUSE:  bus.wcau = 1'b1;
          CP0_EPC:    bus.wepc = 1'b1;
          default:    ;
        endcase
      end
      if (mfc0_ev) begin
        case (bus.rd_id)
          CP0_STATUS: bus.mfc0 = MFC0_STATUS;
          CP0_CAUSE:  bus.mfc0 = MFC0_CAUSE;
          CP0_EPC:    bus.mfc0 = MFC0_EPC;
          default:    bus.mfc0 = MFC0_ALU;
        endcase
      end
    end
  end

  // The pending latch keeps capturing edges in FLUSH so no request is lost.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    int_pend_d = intr_rise | (int_pend_q & ~int_taken);
    case (state_q)
      IDLE: begin
        if (take || eret_ev) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: one task per feature, hand-computed strobe
// vectors, plus a second instance with a two-cycle flush for reset-in-FLUSH.
module tb_exc_ctrl;

  logic clk;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  exc_ctrl_if bus();
  exc_ctrl_if bus2();

  exc_ctrl #(.SYNC_STAGES(2), .FLUSH_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exc_ctrl #(.SYNC_STAGES(2), .FLUSH_CYCLES(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {exc, inta, mtc0, wsta, wcau, wepc, mfc0[1:0], selpc[1:0], cancel_id, cancel_if, intr_ack}
  logic [12:0] obs, obs2;
  assign obs  = {bus.exc, bus.inta, bus.mtc0, bus.wsta, bus.wcau, bus.wepc,
                 bus.mfc0, bus.selpc, bus.cancel_id, bus.cancel_if, bus.intr_ack};
  assign obs2 = {bus2.exc, bus2.inta, bus2.mtc0, bus2.wsta, bus2.wcau, bus2.wepc,
                 bus2.mfc0, bus2.selpc, bus2.cancel_id, bus2.cancel_if, bus2.intr_ack};

  localparam logic [12:0] O_IDLE  = 13'b0_0_0_0_0_0_00_00_0_0_0;
  localparam logic [12:0] O_INT   = 13'b1_1_0_1_1_1_00_10_0_0_1;
  localparam logic [12:0] O_EXC   = 13'b1_0_0_1_1_1_00_10_0_0_0;
  localparam logic [12:0] O_OVR   = 13'b1_0_0_1_1_1_00_10_1_0_0;
  localparam logic [12:0] O_FLUSH = 13'b0_0_0_0_0_0_00_00_0_1_0;
  localparam logic [12:0] O_ERET  = 13'b0_0_0_1_0_0_00_01_0_0_0;
  localparam logic [12:0] O_MTSTA = 13'b0_0_1_1_0_0_00_00_0_0_0;
  localparam logic [12:0] O_MTCAU = 13'b0_0_1_0_1_0_00_00_0_0_0;
  localparam logic [12:0] O_MTEPC = 13'b0_0_1_0_0_1_00_00_0_0_0;
  localparam logic [12:0] O_MTNONE= 13'b0_0_1_0_0_0_00_00_0_0_0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.intr = 0; bus.syscall_id = 0; bus.unimpl_id = 0; bus.eret_id = 0;
    bus.mfc0_id = 0; bus.mtc0_id = 0; bus.rd_id = 5'd0; bus.ovr_exe = 0;
    bus.in_slot_id = 0; bus.stall_id = 0;
    bus2.intr = 0; bus2.syscall_id = 0; bus2.unimpl_id = 0; bus2.eret_id = 0;
    bus2.mfc0_id = 0; bus2.mtc0_id = 0; bus2.rd_id = 5'd0; bus2.ovr_exe = 0;
    bus2.in_slot_id = 0; bus2.stall_id = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.sta = 32'hF; bus2.sta = 32'hF;
    rst = 1'b1; rst2 = 1'b1;
    bus.syscall_id = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, O_IDLE); end
    checks++;
    if (bus.cause !== 32'h0) begin errors++; $display("[TB] FAIL reset_cause got=%h exp=%h", bus.cause, 32'h0); end
    checks++;
    if (obs2 !== O_IDLE) begin errors++; $display("[TB] FAIL reset_outputs2 got=%b exp=%b", obs2, O_IDLE); end
    bus.syscall_id = 1'b0;
    rst = 1'b0; rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL reset_quiet got=%b exp=%b", obs, O_IDLE); end
    end
  endtask

  task automatic test_interrupt();
    clear_inputs();
    bus.sta = 32'hF;
    bus.intr = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_early got=%b exp=%b", obs, O_IDLE); end
    tick();
    bus.intr = 1'b0;
    #1;
    checks++;
    if (obs !== O_INT) begin errors++; $display("[TB] FAIL int_take got=%b exp=%b", obs, O_INT); end
    checks++;
    if (bus.cause !== 32'h0) begin errors++; $display("[TB] FAIL int_cause got=%h exp=%h", bus.cause, 32'h0); end
    tick();
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("[TB] FAIL int_flush got=%b exp=%b", obs, O_FLUSH); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_once got=%b exp=%b", obs, O_IDLE); end
    end
  endtask

  task automatic test_int_masked_slot();
    clear_inputs();
    bus.sta = 32'hE;
    bus.intr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_masked got=%b exp=%b", obs, O_IDLE); end
    end
    bus.intr = 1'b0;
    tick(); tick(); tick();
    bus.sta = 32'hF;
    bus.in_slot_id = 1'b1;
    #1;
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_slot got=%b exp=%b", obs, O_IDLE); end
    tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_slot_hold got=%b exp=%b", obs, O_IDLE); end
    bus.in_slot_id = 1'b0;
    #1;
    checks++;
    if (obs !== O_INT) begin errors++; $display("[TB] FAIL int_unslot got=%b exp=%b", obs, O_INT); end
    tick();
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("[TB] FAIL int_unslot_flush got=%b exp=%b", obs, O_FLUSH); end
    tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL int_pend_clear got=%b exp=%b", obs, O_IDLE); end
  endtask

  task automatic test_syscall();
    clear_inputs();
    bus.sta = 32'hD;
    bus.syscall_id = 1'b1;
    #1;
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL sys_masked got=%b exp=%b", obs, O_IDLE); end
    bus.sta = 32'hF;
    #1;
    checks++;
    if (obs !== O_EXC) begin errors++; $display("[TB] FAIL sys_take got=%b exp=%b", obs, O_EXC); end
    checks++;
    if (bus.cause !== 32'h20) begin errors++; $display("[TB] FAIL sys_cause got=%h exp=%h", bus.cause, 32'h20); end
    tick();
    bus.syscall_id = 1'b0;
    #1;
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("[TB] FAIL sys_flush got=%b exp=%b", obs, O_FLUSH); end
    tick();
    bus.syscall_id = 1'b1;
    bus.stall_id = 1'b1;
    #1;
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL sys_stalled got=%b exp=%b", obs, O_IDLE); end
    tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL sys_stall_hold got=%b exp=%b", obs, O_IDLE); end
    bus.stall_id = 1'b0;
    #1;
    checks++;
    if (obs !== O_EXC) begin errors++; $display("[TB] FAIL sys_after_stall got=%b exp=%b", obs, O_EXC); end
    tick();
    bus.syscall_id = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    clear_inputs();
    bus.sta = 32'hF;
    bus.ovr_exe = 1'b1;
    bus.syscall_id = 1'b1;
    #1;
    checks++;
    if (obs !== O_OVR) begin errors++; $display("[TB] FAIL ovr_take got=%b exp=%b", obs, O_OVR); end
    checks++;
    if (bus.cause !== 32'h30) begin errors++; $display("[TB] FAIL ovr_cause got=%h exp=%h", bus.cause, 32'h30); end
    tick();
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("[TB] FAIL ovr_single got=%b exp=%b", obs, O_FLUSH); end
    bus.ovr_exe = 1'b0;
    bus.syscall_id = 1'b0;
    tick();
    bus.unimpl_id = 1'b1;
    bus.syscall_id = 1'b1;
    #1;
    checks++;
    if (bus.cause !== 32'h28) begin errors++; $display("[TB] FAIL unimpl_cause got=%h exp=%h", bus.cause, 32'h28); end
    tick();
    bus.unimpl_id = 1'b0;
    bus.syscall_id = 1'b0;
    tick();
  endtask

  task automatic test_mtc0_mfc0();
    logic [4:0]  rds [4] = '{5'd12, 5'd13, 5'd14, 5'd5};
    logic [12:0] exps[4] = '{O_MTSTA, O_MTCAU, O_MTEPC, O_MTNONE};
    logic [1:0]  sel [3] = '{2'd1, 2'd2, 2'd3};
    clear_inputs();
    bus.sta = 32'hF;
    bus.mtc0_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rd_id = rds[i];
      #1;
      checks++;
      if (obs !== exps[i]) begin errors++; $display("[TB] FAIL mtc0_rd%0d got=%b exp=%b", rds[i], obs, exps[i]); end
      tick();
    end
    bus.mtc0_id = 1'b0;
    #1;
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL mtc0_noflush got=%b exp=%b", obs, O_IDLE); end
    bus.mfc0_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rd_id = rds[i];
      #1;
      checks++;
      if (bus.mfc0 !== sel[i]) begin errors++; $display("[TB] FAIL mfc0_rd%0d got=%0d exp=%0d", rds[i], bus.mfc0, sel[i]); end
      tick();
    end
    bus.mfc0_id = 1'b0;
    #1;
    checks++;
    if (bus.mfc0 !== 2'd0) begin errors++; $display("[TB] FAIL mfc0_idle got=%0d exp=%0d", bus.mfc0, 2'd0); end
  endtask

  task automatic test_int_vs_mtc0();
    clear_inputs();
    bus.sta = 32'hF;
    bus.mtc0_id = 1'b1;
    bus.rd_id = 5'd13;
    bus.intr = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_MTCAU) begin errors++; $display("[TB] FAIL mtc0_pre_int got=%b exp=%b", obs, O_MTCAU); end
    tick();
    checks++;
    if (obs !== O_INT) begin errors++; $display("[TB] FAIL int_over_mtc0 got=%b exp=%b", obs, O_INT); end
    bus.intr = 1'b0;
    bus.mtc0_id = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_eret();
    clear_inputs();
    bus.sta = 32'hF;
    bus.eret_id = 1'b1;
    #1;
    checks++;
    if (obs !== O_ERET) begin errors++; $display("[TB] FAIL eret got=%b exp=%b", obs, O_ERET); end
    tick();
    bus.eret_id = 1'b0;
    #1;
    checks++;
    if (obs !== O_FLUSH) begin errors++; $display("[TB] FAIL eret_flush got=%b exp=%b", obs, O_FLUSH); end
    tick();
    checks++;
    if (obs !== O_IDLE) begin errors++; $display("[TB] FAIL eret_done got=%b exp=%b", obs, O_IDLE); end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    bus2.sta = 32'hF;
    bus2.syscall_id = 1'b1;
    #1;
    checks++;
    if (obs2 !== O_EXC) begin errors++; $display("[TB] FAIL f2_take got=%b exp=%b", obs2, O_EXC); end
    tick();
    bus2.syscall_id = 1'b0;
    #1;
    checks++;
    if (obs2 !== O_FLUSH) begin errors++; $display("[TB] FAIL f2_flush got=%b exp=%b", obs2, O_FLUSH); end
    rst2 = 1'b1;
    #1;
    checks++;
    if (obs2 !== O_IDLE) begin errors++; $display("[TB] FAIL f2_rst_comb got=%b exp=%b", obs2, O_IDLE); end
    tick();
    rst2 = 1'b0;
    #1;
    checks++;
    if (obs2 !== O_IDLE) begin errors++; $display("[TB] FAIL f2_rst_abort got=%b exp=%b", obs2, O_IDLE); end
    bus2.syscall_id = 1'b1;
    tick();
    bus2.syscall_id = 1'b0;
    tick();
    checks++;
    if (obs2 !== O_FLUSH) begin errors++; $display("[TB] FAIL f2_flush_two got=%b exp=%b", obs2, O_FLUSH); end
    tick();
    checks++;
    if (obs2 !== O_IDLE) begin errors++; $display("[TB] FAIL f2_flush_end got=%b exp=%b", obs2, O_IDLE); end
  endtask

  initial begin
    $display("[TB] exc_ctrl directed tests");
    test_reset();
    test_interrupt();
    test_int_masked_slot();
    test_syscall();
    test_overflow();
    test_mtc0_mfc0();
    test_int_vs_mtc0();
    test_eret();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
